bus_arbiter4: RTL and testbench



---
 rtl/bus_arbiter4.sv | 114 +++++++++++
 tb/tb_bus_arbiter4.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 8-bit bus: four requesters, bounded hold,
// one idle turnaround cycle between owners, registered grant/select outputs.
module bus_arbiter4 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       mCtrl,
    output logic             bus_busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         mctrl_q, mctrl_d;
    logic [1:0]         last_q, last_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   hold_q, hold_d;

    logic [1:0]         win;
    logic [1:0]         idx;
    logic               found;
    logic               others;
    logic               release_now;

    // Scan starts just after the last owner, so it sits at lowest priority.
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign others      = |(req & ~gnt_q);
    assign release_now = !req[mctrl_q] ||
                         ((hold_q == CNT_W'(MAX_HOLD - 1)) && others);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        mctrl_d = mctrl_q;
        last_d  = last_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, TURN: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = 4'(1) << win;
                    mctrl_d = win;
                    last_d  = win;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end else if (hold_q != CNT_W'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            mctrl_q <= 2'd0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            mctrl_q <= mctrl_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt      = gnt_q;
    assign mCtrl    = mctrl_q;
    assign bus_busy = busy_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: expected outputs are queued as each step is
// driven and popped after the following clock edge.
module tb_bus_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] mCtrl;
    logic       bus_busy;
    logic [7:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] g;
        logic [1:0] m;
        logic       b;
        logic [7:0] h;
        string      tag;
    } exp_t;

    exp_t sb[$];

    bus_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .mCtrl(mCtrl), .bus_busy(bus_busy), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk({e.tag, ".gnt"},      {4'b0, gnt},      {4'b0, e.g});
        chk({e.tag, ".mCtrl"},    {6'b0, mCtrl},    {6'b0, e.m});
        chk({e.tag, ".bus_busy"}, {7'b0, bus_busy}, {7'b0, e.b});
        chk({e.tag, ".hold_cnt"}, hold_cnt,         e.h);
        chk({e.tag, ".onehot"},   {7'b0, $onehot0(gnt)}, 8'd1);
    endtask

    // Drive req, queue the outputs expected after the next edge, then compare.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] m,
                        input logic [7:0] h, input string tag);
        exp_t e;
        req = r;
        sb.push_back('{g: g, m: m, b: |g, h: h, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        e = '{g: 4'b0, m: 2'd0, b: 1'b0, h: 8'd0, tag: "reset"};
        check_outputs(e);
        rst = 1'b0;

        // All four requesting: rotation 0,1,2,3,0 with 4-cycle holds and gaps.
        for (int k = 0; k < 5; k++) begin
            logic [1:0] o;
            o = 2'(k);
            for (int h = 0; h < 4; h++)
                step(4'b1111, 4'(1) << o, o, 8'(h), $sformatf("rr%0d_h%0d", k, h));
            step(4'b1111, 4'b0000, o, 8'd0, $sformatf("rr%0d_turn", k));
        end

        // Voluntary release by requester 2.
        for (int h = 0; h < 3; h++)
            step(4'b0100, 4'b0100, 2'd2, 8'(h), $sformatf("rel_h%0d", h));
        step(4'b0000, 4'b0000, 2'd2, 8'd0, "rel_turn");
        step(4'b0000, 4'b0000, 2'd2, 8'd0, "rel_idle0");
        step(4'b0000, 4'b0000, 2'd2, 8'd0, "rel_idle1");

        // Uncontended hold saturates the counter without turnaround.
        for (int k = 0; k < 20; k++)
            step(4'b0010, 4'b0010, 2'd1, 8'((k > 4) ? 4 : k), $sformatf("solo_%0d", k));
        step(4'b0000, 4'b0000, 2'd1, 8'd0, "solo_turn");
        step(4'b0000, 4'b0000, 2'd1, 8'd0, "solo_idle");

        // Async reset while requester 3 owns the bus.
        step(4'b1000, 4'b1000, 2'd3, 8'd0, "ar_h0");
        step(4'b1000, 4'b1000, 2'd3, 8'd1, "ar_h1");
        #2;
        rst = 1'b1;
        #1;
        e = '{g: 4'b0, m: 2'd0, b: 1'b0, h: 8'd0, tag: "ar_async"};
        check_outputs(e);
        rst = 1'b0;

        // Wrap and late arrival: 3 is preempted by 1 after exactly 4 cycles.
        step(4'b1000, 4'b1000, 2'd3, 8'd0, "wrap_h0");
        step(4'b1000, 4'b1000, 2'd3, 8'd1, "wrap_h1");
        step(4'b1010, 4'b1000, 2'd3, 8'd2, "wrap_h2");
        step(4'b1010, 4'b1000, 2'd3, 8'd3, "wrap_h3");
        step(4'b1010, 4'b0000, 2'd3, 8'd0, "wrap_turn");
        step(4'b1010, 4'b0010, 2'd1, 8'd0, "late_h0");
        step(4'b1010, 4'b0010, 2'd1, 8'd1, "late_h1");
        step(4'b1010, 4'b0010, 2'd1, 8'd2, "late_h2");
        step(4'b1010, 4'b0010, 2'd1, 8'd3, "late_h3");
        step(4'b1010, 4'b0000, 2'd1, 8'd0, "late_turn");
        step(4'b1010, 4'b1000, 2'd3, 8'd0, "back3_h0");
        step(4'b1010, 4'b1000, 2'd3, 8'd1, "back3_h1");
        step(4'b1010, 4'b1000, 2'd3, 8'd2, "back3_h2");
        step(4'b1010, 4'b1000, 2'd3, 8'd3, "back3_h3");
        // Owner drops at the preemption point; release path, same outcome.
        step(4'b0010, 4'b0000, 2'd3, 8'd0, "drop_turn");
        step(4'b0010, 4'b0010, 2'd1, 8'd0, "drop_next");
        step(4'b0000, 4'b0000, 2'd1, 8'd0, "end_turn");
        step(4'b0000, 4'b0000, 2'd1, 8'd0, "end_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
